// File: rtl/hazard_trap_ctrl.sv
// rtl/hazard_trap_ctrl.sv - pipeline stall/flush and trap sequencing controller
//
// Purpose: drives stall/flush of the 5-stage core for load-use hazards, taken
// branches and memory wait states, and sequences trap entry/return
// (RUN -> DRAIN -> TRAP -> RUN) with a registered one-cycle pulse.
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   id_*_i                         decode-stage valid and source registers
//   ex_*_i                         execute-stage valid/load/rd/exception/branch
//   mem_valid_i, wb_valid_i        later stages occupied
//   mem_busy_i                     data memory wait state
//   fetch_stall_o, id_stall_o,
//   id_flush_o, ex_flush_o,
//   ex_stall_o                     combinational pipeline controls
//   trap_enter_o, trap_return_o    registered one-cycle pulses
//   trap_cause_o                   0 ILLEGAL, 1 ECALL, 2 EBREAK, 3 MRET
//   drain_timeout_o                sticky drain timeout flag
//   stall_cycles_o                 saturating fetch-stall cycle count
module hazard_trap_ctrl #(
    parameter int DRAIN_MAX = 15,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             ex_valid_i,
    input  logic             ex_load_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic [3:0]       ex_exception_i,
    input  logic             ex_branch_taken_i,
    input  logic             mem_valid_i,
    input  logic             wb_valid_i,
    input  logic             mem_busy_i,
    output logic             fetch_stall_o,
    output logic             id_stall_o,
    output logic             id_flush_o,
    output logic             ex_flush_o,
    output logic             ex_stall_o,
    output logic             trap_enter_o,
    output logic             trap_return_o,
    output logic [1:0]       trap_cause_o,
    output logic             drain_timeout_o,
    output logic [CNT_W-1:0] stall_cycles_o
);

    localparam int DW = $clog2(DRAIN_MAX + 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_TRAP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
    logic [1:0]       cause_q, cause_d;
    logic             timeout_q, timeout_d;
    logic             trap_enter_q, trap_enter_d;
    logic             trap_return_q, trap_return_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic exc;
    logic lu;
    logic pipe_empty;

    assign exc = ex_valid_i & (|ex_exception_i);
    assign lu  = id_valid_i & ex_valid_i & ex_load_i & (ex_rd_addr_i != 5'd0) &
                 ((ex_rd_addr_i == id_rs1_addr_i) | (ex_rd_addr_i == id_rs2_addr_i));
    assign pipe_empty = ~mem_valid_i & ~wb_valid_i & ~mem_busy_i;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_RUN;
            drain_cnt_q   <= '0;
            cause_q       <= 2'd0;
            timeout_q     <= 1'b0;
            trap_enter_q  <= 1'b0;
            trap_return_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            cause_q       <= cause_d;
            timeout_q     <= timeout_d;
            trap_enter_q  <= trap_enter_d;
            trap_return_q <= trap_return_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        cause_d     = cause_q;
        timeout_d   = timeout_q;
        unique case (state_q)
            S_RUN: begin
                if (exc) begin
                    // Lowest set bit wins: ILLEGAL > ECALL > EBREAK > MRET
                    if (ex_exception_i[0])      cause_d = 2'd0;
                    else if (ex_exception_i[1]) cause_d = 2'd1;
                    else if (ex_exception_i[2]) cause_d = 2'd2;
                    else                        cause_d = 2'd3;
                    drain_cnt_d = '0;
                    state_d     = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pipe_empty) begin
                    state_d = S_TRAP;
                end else if (drain_cnt_q == DW'(DRAIN_MAX)) begin
                    timeout_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            S_TRAP:  state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    // Output logic
    always_comb begin
        fetch_stall_o = 1'b0;
        id_stall_o    = 1'b0;
        id_flush_o    = 1'b0;
        ex_flush_o    = 1'b0;
        ex_stall_o    = 1'b0;
        if (state_q == S_RUN) begin
            if (exc) begin
                fetch_stall_o = 1'b1;
                id_flush_o    = 1'b1;
                ex_flush_o    = 1'b1;
            end else if (ex_branch_taken_i) begin
                // Branch resolved in execute: only the younger fetch/decode die
                id_flush_o = 1'b1;
            end else if (mem_busy_i) begin
                fetch_stall_o = 1'b1;
                id_stall_o    = 1'b1;
                ex_stall_o    = 1'b1;
            end else if (lu) begin
                // Load moves on; decode holds and injects a bubble into execute
                fetch_stall_o = 1'b1;
                id_stall_o    = 1'b1;
            end
        end else begin
            fetch_stall_o = 1'b1;
            id_flush_o    = 1'b1;
            ex_flush_o    = 1'b1;
        end

        trap_enter_d  = (state_q == S_TRAP) && (cause_q != 2'd3);
        trap_return_d = (state_q == S_TRAP) && (cause_q == 2'd3);

        stall_cnt_d = stall_cnt_q;
        if (fetch_stall_o && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    assign trap_enter_o    = trap_enter_q;
    assign trap_return_o   = trap_return_q;
    assign trap_cause_o    = cause_q;
    assign drain_timeout_o = timeout_q;
    assign stall_cycles_o  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_trap_ctrl.sv
// tb/tb_hazard_trap_ctrl.sv - scoreboard bench for hazard_trap_ctrl
module tb_hazard_trap_ctrl;

    localparam int CW  = 4;
    localparam int DMX = 15;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          id_valid_i = 0;
    logic [4:0]    id_rs1_addr_i = 0, id_rs2_addr_i = 0;
    logic          ex_valid_i = 0, ex_load_i = 0;
    logic [4:0]    ex_rd_addr_i = 0;
    logic [3:0]    ex_exception_i = 0;
    logic          ex_branch_taken_i = 0, mem_valid_i = 0, wb_valid_i = 0, mem_busy_i = 0;
    logic          fetch_stall_o, id_stall_o, id_flush_o, ex_flush_o, ex_stall_o;
    logic          trap_enter_o, trap_return_o, drain_timeout_o;
    logic [1:0]    trap_cause_o;
    logic [CW-1:0] stall_cycles_o;

    hazard_trap_ctrl #(.DRAIN_MAX(DMX), .CNT_W(CW)) dut (
        .clk(clk), .rstn(rstn),
        .id_valid_i(id_valid_i), .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .ex_valid_i(ex_valid_i), .ex_load_i(ex_load_i), .ex_rd_addr_i(ex_rd_addr_i),
        .ex_exception_i(ex_exception_i), .ex_branch_taken_i(ex_branch_taken_i),
        .mem_valid_i(mem_valid_i), .wb_valid_i(wb_valid_i), .mem_busy_i(mem_busy_i),
        .fetch_stall_o(fetch_stall_o), .id_stall_o(id_stall_o), .id_flush_o(id_flush_o),
        .ex_flush_o(ex_flush_o), .ex_stall_o(ex_stall_o),
        .trap_enter_o(trap_enter_o), .trap_return_o(trap_return_o),
        .trap_cause_o(trap_cause_o), .drain_timeout_o(drain_timeout_o),
        .stall_cycles_o(stall_cycles_o)
    );

    always #5 clk = ~clk;

    // Output vector: {fs, ids, idf, exf, exs, enter, ret, cause[1:0], timeout, cnt[3:0]}
    typedef logic [14:0] obs_t;
    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    // Reference model: phase 0 running, 1 draining, 2 trapping
    int   m_phase, m_dcnt, m_cause, m_cnt;
    bit   m_enter, m_ret, m_to;

    function automatic obs_t pack_obs(bit fs, bit ids, bit idf, bit exf, bit exs,
                                      bit en, bit rt, int cs, bit to, int cnt);
        obs_t o;
        o = {fs, ids, idf, exf, exs, en, rt, 2'(cs), to, 4'(cnt)};
        return o;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_dcnt = 0; m_cause = 0; m_cnt = 0;
        m_enter = 0; m_ret = 0; m_to = 0;
    endtask

    // Compute expected outputs for the inputs now on the bus, then advance model.
    task automatic step();
        bit exc, lu, fs, ids, idf, exf, exs;
        exc = ex_valid_i && (ex_exception_i != 0);
        lu  = id_valid_i && ex_valid_i && ex_load_i && ex_rd_addr_i != 0 &&
              (ex_rd_addr_i == id_rs1_addr_i || ex_rd_addr_i == id_rs2_addr_i);
        {fs, ids, idf, exf, exs} = 5'b0;
        if (m_phase != 0)          {fs, idf, exf} = 3'b111;
        else if (exc)              {fs, idf, exf} = 3'b111;
        else if (ex_branch_taken_i) idf = 1;
        else if (mem_busy_i)       {fs, ids, exs} = 3'b111;
        else if (lu)               {fs, ids} = 2'b11;
        exp_q.push_back(pack_obs(fs, ids, idf, exf, exs, m_enter, m_ret, m_cause, m_to, m_cnt));

        m_enter = 0; m_ret = 0;
        if (fs && m_cnt < (1 << CW) - 1) m_cnt++;
        case (m_phase)
            0: if (exc) begin
                if (ex_exception_i[0])      m_cause = 0;
                else if (ex_exception_i[1]) m_cause = 1;
                else if (ex_exception_i[2]) m_cause = 2;
                else                        m_cause = 3;
                m_phase = 1; m_dcnt = 0;
            end
            1: if (!mem_valid_i && !wb_valid_i && !mem_busy_i) m_phase = 2;
               else if (m_dcnt == DMX) begin m_to = 1; m_phase = 2; end
               else m_dcnt++;
            default: begin
                if (m_cause == 3) m_ret = 1; else m_enter = 1;
                m_phase = 0;
            end
        endcase
        @(negedge clk);
        cyc++;
    endtask

    task automatic quiet();
        id_valid_i = 0; id_rs1_addr_i = 0; id_rs2_addr_i = 0;
        ex_valid_i = 0; ex_load_i = 0; ex_rd_addr_i = 0; ex_exception_i = 0;
        ex_branch_taken_i = 0; mem_valid_i = 0; wb_valid_i = 0; mem_busy_i = 0;
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic do_reset();
        quiet();
        #1 rstn = 0;
        model_reset();
        exp_q.push_back('0);
        @(negedge clk);
        rstn = 1;
    endtask

    task automatic set_lu(bit ld, int rd, int rs1, int rs2);
        quiet();
        id_valid_i = 1; ex_valid_i = 1; ex_load_i = ld;
        ex_rd_addr_i = 5'(rd); id_rs1_addr_i = 5'(rs1); id_rs2_addr_i = 5'(rs2);
    endtask

    task automatic run_exc(logic [3:0] e, int busy_cycles);
        quiet(); ex_valid_i = 1; ex_exception_i = e; mem_valid_i = 1; wb_valid_i = 1;
        step();
        quiet(); mem_valid_i = 1; wb_valid_i = 1;
        repeat (busy_cycles) step();
        quiet();
        repeat (4) step();
    endtask

    task automatic rand_inputs(bit stuck);
        id_valid_i        = 1'($urandom);
        id_rs1_addr_i     = 5'($urandom_range(0, 3));
        id_rs2_addr_i     = 5'($urandom_range(0, 3));
        ex_valid_i        = 1'($urandom);
        ex_load_i         = 1'($urandom);
        ex_rd_addr_i      = 5'($urandom_range(0, 3));
        ex_exception_i    = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'd0;
        ex_branch_taken_i = ($urandom_range(0, 3) == 0);
        mem_valid_i       = stuck ? 1'b1 : ($urandom_range(0, 2) == 0);
        wb_valid_i        = ($urandom_range(0, 2) == 0);
        mem_busy_i        = ($urandom_range(0, 4) == 0);
    endtask

    // Monitor: samples mid-low-phase, pops and compares against the scoreboard.
    initial begin
        obs_t act, exp;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                act = {fetch_stall_o, id_stall_o, id_flush_o, ex_flush_o, ex_stall_o,
                       trap_enter_o, trap_return_o, trap_cause_o, drain_timeout_o, stall_cycles_o};
                n_checks++;
                if (act === exp) n_pass++;
                else $display("FAIL cycle_%0d outputs {fs,ids,idf,exf,exs,en,ret,cause,to,cnt}: got %b required %b",
                              cyc, act, exp);
            end
        end
    end

    initial begin
        model_reset();
        quiet();
        @(negedge clk);
        do_reset();
        repeat (2) step();

        // Load-use on rs2, then rd=0 (no hazard), then branch overriding load-use
        set_lu(1, 5, 1, 5); step();
        set_lu(1, 0, 0, 0); step();
        set_lu(1, 5, 5, 2); ex_branch_taken_i = 1; step();
        quiet(); step();

        // ECALL with pipeline draining over a few cycles, then multi-hot and MRET
        run_exc(4'b0010, 2);
        run_exc(4'b1001, 0);
        run_exc(4'b1000, 1);
        run_exc(4'b0100, 0);

        // Drain timeout with memory stage stuck
        quiet(); ex_valid_i = 1; ex_exception_i = 4'b0001; mem_valid_i = 1; step();
        quiet(); mem_valid_i = 1; repeat (18) step();
        quiet(); repeat (3) step();

        // Counter saturation under a long memory wait
        do_reset();
        quiet(); mem_busy_i = 1; repeat (20) step();
        quiet(); step();

        // Reset in the middle of a drain: no pulse afterwards
        do_reset();
        quiet(); ex_valid_i = 1; ex_exception_i = 4'b0010; mem_valid_i = 1; step();
        quiet(); mem_valid_i = 1; repeat (3) step();
        do_reset();
        quiet(); repeat (3) step();

        // Randomized traffic with occasional stuck-memory segments and resets
        for (int seg = 0; seg < 12; seg++) begin
            bit stuck;
            stuck = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 60; i++) begin
                rand_inputs(stuck);
                step();
            end
            if (seg % 4 == 3) do_reset();
        end
        quiet();
        step();
        @(negedge clk);
        #5;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: got no completion required completion");
        $fatal(1, "bench timeout");
    end

endmodule
